freq_divider: RTL and testbench

- Measurement-based frequency divider; the divide-by-2^n counterpart of the team's frequency multiplier, using the same adjust/valid control style.
- Measures the high phase of `infreq` in `clk` cycles, then generates `outfreq` with half-period = measured high time << n.
- For a 50% duty `infreq`, `outfreq` = f_in / 2^n.
- Sits between the input-clock measurement front end and downstream timing logic.

---
 rtl/freq_divider.sv | 151 +++++++++++++++
 tb/tb_freq_divider.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/freq_divider.sv
// freq_divider: measures the high phase of infreq in clk cycles and regenerates a
// square wave whose half-period is high_time << n. Optional macro: FREQ_DIV_SYNC_EN.
module freq_divider #(
  parameter int CNT_W = 16,
  parameter int N_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adjust,
  input  logic             infreq,
  input  logic [N_W-1:0]   n,
  output logic             valid,
  output logic             outfreq,
  output logic [CNT_W-1:0] high_time,
  output logic             err
);

  localparam int SH_W = CNT_W + (1 << N_W) - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, READY, SYNC, MEASURE, LOAD, GEN} state_t;

  state_t           state_q, state_d;
  logic             in_s, prev_q, rise, fall;
  logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] gen_cnt_q, gen_cnt_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             outfreq_q, outfreq_d;
  logic             err_q, err_d;
  logic [SH_W-1:0]  shifted;

`ifdef FREQ_DIV_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= infreq;
      sync2_q <= sync1_q;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = infreq;
`endif

  assign rise = ~prev_q & in_s;
  assign fall = prev_q & ~in_s;

  always_comb begin
    state_d     = state_q;
    meas_cnt_d  = meas_cnt_q;
    half_d      = half_q;
    gen_cnt_d   = gen_cnt_q;
    high_time_d = high_time_q;
    outfreq_d   = outfreq_q;
    err_d       = err_q;
    shifted     = SH_W'(meas_cnt_q) << n;

    case (state_q)
      IDLE: begin
        if (adjust) state_d = READY;
      end
      READY: begin
        err_d = 1'b0;
        if (!adjust) state_d = SYNC;
      end
      SYNC: begin
        if (adjust) begin
          state_d = READY;
        end else if (rise) begin
          meas_cnt_d = CNT_ONE;
          state_d    = MEASURE;
        end
      end
      MEASURE: begin
        if (adjust) begin
          state_d = READY;
        end else if (fall) begin
          state_d = LOAD;
        end else if (in_s) begin
          if (meas_cnt_q == CNT_MAX) err_d = 1'b1;
          else meas_cnt_d = meas_cnt_q + CNT_ONE;
        end
      end
      LOAD: begin
        high_time_d = meas_cnt_q;
        // anything above CNT_W bits after the shift cannot be represented
        if (|shifted[SH_W-1:CNT_W]) begin
          half_d = CNT_MAX;
          err_d  = 1'b1;
        end else begin
          half_d = shifted[CNT_W-1:0];
        end
        gen_cnt_d = CNT_ONE;
        outfreq_d = 1'b0;
        state_d   = GEN;
      end
      GEN: begin
        if (adjust) begin
          state_d = READY;
        end else if (gen_cnt_q == half_q) begin
          outfreq_d = ~outfreq_q;
          gen_cnt_d = CNT_ONE;
        end else begin
          gen_cnt_d = gen_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == READY) outfreq_d = 1'b0;
    valid_d = (state_d == GEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= 1'b0;
      meas_cnt_q  <= '0;
      half_q      <= '0;
      gen_cnt_q   <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      outfreq_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= in_s;
      meas_cnt_q  <= meas_cnt_d;
      half_q      <= half_d;
      gen_cnt_q   <= gen_cnt_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      outfreq_q   <= outfreq_d;
      err_q       <= err_d;
    end
  end

  assign valid     = valid_q;
  assign outfreq   = outfreq_q;
  assign high_time = high_time_q;
  assign err       = err_q;

endmodule

// File: tb/tb_freq_divider.sv
// Directed bench for freq_divider: measurement, ratio, saturation, partial-high,
// adjust/abort and asynchronous reset scenarios.
module tb_freq_divider;
  localparam int CNT_W = 16;
  localparam int N_W   = 3;

  logic             clk = 1'b0;
  logic             rst, adjust, infreq;
  logic [N_W-1:0]   n;
  logic             valid, outfreq, err;
  logic [CNT_W-1:0] high_time;
  int               tests = 0;
  int               fails = 0;

  freq_divider #(.CNT_W(CNT_W), .N_W(N_W)) dut (
    .clk(clk), .rst(rst), .adjust(adjust), .infreq(infreq), .n(n),
    .valid(valid), .outfreq(outfreq), .high_time(high_time), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // adjust pulse, then a clean high phase of hi cycles; returns just after GEN entry
  task automatic measure(input int hi, input logic [N_W-1:0] nv);
    @(negedge clk); adjust = 1'b1; infreq = 1'b0; n = nv;
    @(negedge clk); adjust = 1'b0;
    @(negedge clk); infreq = 1'b1;
    cyc(hi);
    infreq = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset;
    rst = 1'b1; adjust = 1'b0; infreq = 1'b0; n = '0;
    cyc(2);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
    tests++; if (outfreq !== 1'b0) begin fails++; $display("FAIL reset_outfreq: got %b expected 0", outfreq); end
    tests++; if (high_time !== 16'd0) begin fails++; $display("FAIL reset_high_time: got %0d expected 0", high_time); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_basic;
    measure(5, 3'd2);
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b expected 1", valid); end
    tests++; if (high_time !== 16'd5) begin fails++; $display("FAIL basic_high_time: got %0d expected 5", high_time); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b expected 0", err); end
    cyc(19);
    tests++; if (outfreq !== 1'b0) begin fails++; $display("FAIL basic_low_19: got %b expected 0", outfreq); end
    cyc(1);
    tests++; if (outfreq !== 1'b1) begin fails++; $display("FAIL basic_rise_20: got %b expected 1", outfreq); end
    cyc(19);
    tests++; if (outfreq !== 1'b1) begin fails++; $display("FAIL basic_high_39: got %b expected 1", outfreq); end
    cyc(1);
    tests++; if (outfreq !== 1'b0) begin fails++; $display("FAIL basic_fall_40: got %b expected 0", outfreq); end
  endtask

  task automatic test_ratio;
    measure(5, 3'd0);
    tests++; if (high_time !== 16'd5) begin fails++; $display("FAIL n0_high_time: got %0d expected 5", high_time); end
    cyc(4);
    tests++; if (outfreq !== 1'b0) begin fails++; $display("FAIL n0_low_4: got %b expected 0", outfreq); end
    cyc(1);
    tests++; if (outfreq !== 1'b1) begin fails++; $display("FAIL n0_rise_5: got %b expected 1", outfreq); end
    cyc(5);
    tests++; if (outfreq !== 1'b0) begin fails++; $display("FAIL n0_fall_10: got %b expected 0", outfreq); end
    measure(5, 3'd7);
    cyc(639);
    tests++; if (outfreq !== 1'b0) begin fails++; $display("FAIL n7_low_639: got %b expected 0", outfreq); end
    cyc(1);
    tests++; if (outfreq !== 1'b1) begin fails++; $display("FAIL n7_rise_640: got %b expected 1", outfreq); end
    cyc(640);
    tests++; if (outfreq !== 1'b0) begin fails++; $display("FAIL n7_fall_1280: got %b expected 0", outfreq); end
  endtask

  task automatic test_saturate;
    measure(5000, 3'd4);
    tests++; if (high_time !== 16'd5000) begin fails++; $display("FAIL sat_high_time: got %0d expected 5000", high_time); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL sat_err: got %b expected 1", err); end
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL sat_valid: got %b expected 1", valid); end
    cyc(65534);
    tests++; if (outfreq !== 1'b0) begin fails++; $display("FAIL sat_low_65534: got %b expected 0", outfreq); end
    cyc(1);
    tests++; if (outfreq !== 1'b1) begin fails++; $display("FAIL sat_rise_65535: got %b expected 1", outfreq); end
    adjust = 1'b1;
    cyc(2);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL sat_err_clear: got %b expected 0", err); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL sat_ready_valid: got %b expected 0", valid); end
  endtask

  task automatic test_partial_high;
    @(negedge clk); adjust = 1'b1; infreq = 1'b1; n = 3'd0;
    @(negedge clk); adjust = 1'b0;
    cyc(2);
    infreq = 1'b0;
    cyc(6);
    infreq = 1'b1;
    cyc(6);
    infreq = 1'b0;
    cyc(2);
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL partial_valid: got %b expected 1", valid); end
    tests++; if (high_time !== 16'd6) begin fails++; $display("FAIL partial_high_time: got %0d expected 6", high_time); end
    cyc(5);
    tests++; if (outfreq !== 1'b0) begin fails++; $display("FAIL partial_low_5: got %b expected 0", outfreq); end
    cyc(1);
    tests++; if (outfreq !== 1'b1) begin fails++; $display("FAIL partial_rise_6: got %b expected 1", outfreq); end
  endtask

  task automatic test_adjust_abort;
    adjust = 1'b1;
    cyc(1);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL abort_gen_valid: got %b expected 0", valid); end
    tests++; if (outfreq !== 1'b0) begin fails++; $display("FAIL abort_gen_outfreq: got %b expected 0", outfreq); end
    cyc(1);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL abort_ready_hold: got %b expected 0", valid); end
    measure(3, 3'd1);
    tests++; if (high_time !== 16'd3) begin fails++; $display("FAIL remeas_high_time: got %0d expected 3", high_time); end
    cyc(5);
    tests++; if (outfreq !== 1'b0) begin fails++; $display("FAIL remeas_low_5: got %b expected 0", outfreq); end
    cyc(1);
    tests++; if (outfreq !== 1'b1) begin fails++; $display("FAIL remeas_rise_6: got %b expected 1", outfreq); end
    // falling edge and adjust together must discard the 4-cycle measurement
    @(negedge clk); adjust = 1'b1;
    @(negedge clk); adjust = 1'b0;
    @(negedge clk); infreq = 1'b1;
    cyc(4);
    adjust = 1'b1; infreq = 1'b0;
    cyc(3);
    tests++; if (high_time !== 16'd3) begin fails++; $display("FAIL abort_meas_high_time: got %0d expected 3", high_time); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL abort_meas_valid: got %b expected 0", valid); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); adjust = 1'b0;
    @(negedge clk); infreq = 1'b1;
    cyc(3);
    #2 rst = 1'b1;
    #1;
    tests++; if (high_time !== 16'd0) begin fails++; $display("FAIL rst_meas_high_time: got %0d expected 0", high_time); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL rst_meas_valid: got %b expected 0", valid); end
    @(negedge clk); rst = 1'b0;
    cyc(2); infreq = 1'b0;
    cyc(3); infreq = 1'b1;
    cyc(3); infreq = 1'b0;
    cyc(3);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL rst_idle_valid: got %b expected 0", valid); end
    tests++; if (high_time !== 16'd0) begin fails++; $display("FAIL rst_idle_high_time: got %0d expected 0", high_time); end
    measure(4, 3'd0);
    tests++; if (high_time !== 16'd4) begin fails++; $display("FAIL rst_remeas_high_time: got %0d expected 4", high_time); end
    cyc(4);
    tests++; if (outfreq !== 1'b1) begin fails++; $display("FAIL rst_remeas_rise: got %b expected 1", outfreq); end
    #2 rst = 1'b1;
    #1;
    tests++; if (outfreq !== 1'b0) begin fails++; $display("FAIL rst_gen_outfreq: got %b expected 0", outfreq); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL rst_gen_valid: got %b expected 0", valid); end
    tests++; if (high_time !== 16'd0) begin fails++; $display("FAIL rst_gen_high_time: got %0d expected 0", high_time); end
    @(negedge clk); rst = 1'b0;
    measure(600, 3'd7);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL rst_sat_err: got %b expected 1", err); end
    tests++; if (high_time !== 16'd600) begin fails++; $display("FAIL rst_sat_high_time: got %0d expected 600", high_time); end
    cyc(3);
    #2 rst = 1'b1;
    #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_gen_err: got %b expected 0", err); end
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ratio;
    test_saturate;
    test_partial_high;
    test_adjust_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
